led_pwm_bank: RTL and testbench

LED_PWM_BANK -- requirements
Module: led_pwm_bank

---
 rtl/led_pkg.sv | 14 +
 rtl/led_pwm_bank_if.sv | 26 ++
 rtl/pwm_compare_ch.sv | 28 ++
 rtl/led_pwm_bank.sv | 94 +++++++++
 tb/tb_led_pwm_bank.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared constants and control-FSM encoding for the eight-channel LED PWM bank.
package led_pkg;

    localparam int unsigned NUM_LEDS       = 8;
    localparam int unsigned CH_W           = 3;
    localparam int unsigned PWM_PERIOD_DEF = 4000;
    localparam int unsigned DUTY_W_DEF     = 12;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/led_pwm_bank_if.sv
// Duty-write handshake plus commit request between an upstream controller and the PWM bank.
interface led_pwm_bank_if #(
    parameter int unsigned DUTY_W = led_pkg::DUTY_W_DEF
);
    logic                      duty_valid;
    logic                      duty_ready;
    logic [led_pkg::CH_W-1:0]  duty_ch;
    logic [DUTY_W-1:0]         duty_val;
    logic                      commit;

    modport master (
        output duty_valid,
        output duty_ch,
        output duty_val,
        output commit,
        input  duty_ready
    );

    modport slave (
        input  duty_valid,
        input  duty_ch,
        input  duty_val,
        input  commit,
        output duty_ready
    );
endinterface

// File: rtl/pwm_compare_ch.sv
// One PWM channel: active duty register loaded at period boundaries and a registered compare.
module pwm_compare_ch #(
    parameter int unsigned DUTY_W = led_pkg::DUTY_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [DUTY_W-1:0] load_val,
    input  logic [DUTY_W-1:0] cnt,
    output logic              led
);

    logic [DUTY_W-1:0] active;

    // Compare uses the pre-load active value; a new duty shows from the next period start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            active <= '0;
            led    <= 1'b0;
        end else begin
            if (load) begin
                active <= load_val;
            end
            led <= (cnt < active);
        end
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Eight-channel LED PWM bank: shadow duty registers written over a handshake and
// transferred atomically to the active compare channels at the next period boundary.
module led_pwm_bank #(
    parameter int unsigned PWM_PERIOD = led_pkg::PWM_PERIOD_DEF,
    parameter int unsigned DUTY_W     = led_pkg::DUTY_W_DEF
) (
    input  logic                          CLK,
    input  logic                          RST,
    led_pwm_bank_if.slave                 bus,
    output logic [led_pkg::NUM_LEDS-1:0]  led,
    output logic                          period_tick,
    output logic                          applied
);
    import led_pkg::*;

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PWM_PERIOD);

    state_t            state;
    state_t            state_nxt;
    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] cnt_nxt_c;
    logic [DUTY_W-1:0] wr_val_c;
    logic              accept_c;
    logic              transfer_c;
    logic              ready_q;
    logic [DUTY_W-1:0] shadow [NUM_LEDS];

    assign bus.duty_ready = ready_q;
    assign cnt_nxt_c      = (cnt == CNT_LAST) ? '0 : cnt + DUTY_W'(1);
    assign wr_val_c       = (bus.duty_val > DUTY_MAX) ? DUTY_MAX : bus.duty_val;

    // Period counter and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            period_tick <= 1'b0;
            applied     <= 1'b0;
            ready_q     <= 1'b0;
            state       <= IDLE;
        end else begin
            cnt         <= cnt_nxt_c;
            period_tick <= (cnt_nxt_c == CNT_LAST);
            applied     <= transfer_c;
            ready_q     <= (state_nxt == IDLE);
            state       <= state_nxt;
        end
    end

    // Commit arms a transfer; the transfer fires on the last cycle of the period.
    always_comb begin
        state_nxt  = state;
        transfer_c = 1'b0;
        accept_c   = bus.duty_valid & ready_q;
        case (state)
            IDLE: begin
                if (bus.commit) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (cnt == CNT_LAST) begin
                    transfer_c = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                shadow[i] <= '0;
            end
        end else if (accept_c) begin
            shadow[bus.duty_ch] <= wr_val_c;
        end
    end

    for (genvar g = 0; g < int'(NUM_LEDS); g++) begin : g_ch
        pwm_compare_ch #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .load     (transfer_c),
            .load_val (shadow[g]),
            .cnt      (cnt),
            .led      (led[g])
        );
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Self-checking bench for led_pwm_bank: directed scenarios plus random traffic against a
// behavioural model of the period counter, shadow/active duties and commit handshake.
module tb_led_pwm_bank;
    import led_pkg::*;

    localparam int unsigned P  = 10;
    localparam int unsigned DW = 12;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [NUM_LEDS-1:0] led;
    logic                period_tick;
    logic                applied;

    int n_cmp = 0;
    int n_bad = 0;
    int n_app = 0;
    int hi [NUM_LEDS];
    int hi_rdy;
    int hi_app;

    led_pwm_bank_if #(.DUTY_W(DW)) bus ();

    led_pwm_bank #(
        .PWM_PERIOD (P),
        .DUTY_W     (DW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus),
        .led         (led),
        .period_tick (period_tick),
        .applied     (applied)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: m_k counts clock edges since reset, so the counter is m_k mod P.
    int unsigned m_k = 0;
    logic        m_pending = 1'b0;
    int unsigned m_shadow [NUM_LEDS] = '{default: 0};
    int unsigned m_active [NUM_LEDS] = '{default: 0};
    logic [7:0]  m_led = 8'h00;
    logic        m_applied = 1'b0;

    always @(posedge CLK or posedge RST) begin
        int unsigned c;
        logic        rdy;
        logic        xfer;
        if (RST) begin
            m_k       <= 0;
            m_pending <= 1'b0;
            m_led     <= 8'h00;
            m_applied <= 1'b0;
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                m_shadow[i] <= 0;
                m_active[i] <= 0;
            end
        end else begin
            c    = m_k % P;
            rdy  = (m_k != 0) && !m_pending;
            xfer = m_pending && (c == P - 1);
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                m_led[i] <= (c < m_active[i]);
                if (xfer) m_active[i] <= m_shadow[i];
            end
            if (bus.duty_valid && rdy)
                m_shadow[bus.duty_ch] <= (int'(bus.duty_val) > int'(P)) ? P : int'(bus.duty_val);
            m_pending <= xfer ? 1'b0 : (m_pending | bus.commit);
            m_applied <= xfer;
            m_k       <= m_k + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        chk("led", 32'(led), 32'(m_led));
        chk("period_tick", 32'(period_tick), 32'((m_k % P) == P - 1));
        chk("applied", 32'(applied), 32'(m_applied));
        chk("duty_ready", 32'(bus.duty_ready), 32'(!RST && m_k != 0 && !m_pending));
        if (applied) n_app++;
    end

    task automatic tick1();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cnt(input int unsigned v);
        for (int k = 0; k < int'(2 * P) && (m_k % P) != v; k++) tick1();
        if ((m_k % P) != v) chk("wait_cnt_timeout", 32'(m_k % P), 32'(v));
    endtask

    task automatic wait_applied(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            tick1();
            if (applied) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("applied_timeout", 0, 1);
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick1();
        bus.commit = 1'b0;
    endtask

    // Offers one write and holds it until accepted; apps reports applied pulses seen meanwhile.
    task automatic write(input int unsigned ch, input int unsigned val, output int apps);
        int n0;
        bit ok;
        n0 = n_app;
        ok = 1'b0;
        apps = 0;
        bus.duty_valid = 1'b1;
        bus.duty_ch    = 3'(ch);
        bus.duty_val   = DW'(val);
        for (int k = 0; k < 100; k++) begin
            if (bus.duty_ready) begin
                apps = n_app - n0 + int'(applied);
                ok = 1'b1;
                tick1();
                break;
            end
            tick1();
        end
        bus.duty_valid = 1'b0;
        if (!ok) chk("write_timeout", 0, 1);
    endtask

    task automatic run_window(input int n);
        for (int i = 0; i < int'(NUM_LEDS); i++) hi[i] = 0;
        hi_rdy = 0;
        hi_app = 0;
        for (int k = 0; k < n; k++) begin
            tick1();
            for (int i = 0; i < int'(NUM_LEDS); i++) hi[i] += int'(led[i]);
            hi_rdy += int'(bus.duty_ready);
            hi_app += int'(applied);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int lat;
        int n0;
        int others;
        bus.duty_valid = 1'b0;
        bus.duty_ch    = '0;
        bus.duty_val   = '0;
        bus.commit     = 1'b0;

        repeat (3) tick1();
        chk("rst_led", 32'(led), 0);
        chk("rst_ready", 32'(bus.duty_ready), 0);
        chk("rst_applied", 32'(applied), 0);
        RST = 1'b0;
        tick1();
        chk("ready_first_edge", 32'(bus.duty_ready), 1);

        // ch0=3, ch7=10, commit
        write(0, 3, a);
        write(7, 10, a);
        n0 = n_app;
        do_commit();
        wait_applied(lat);
        run_window(10);
        others = 0;
        for (int i = 1; i < 7; i++) others += hi[i];
        chk("s1_led0_on_cycles", 32'(hi[0]), 3);
        chk("s1_led7_on_cycles", 32'(hi[7]), 10);
        chk("s1_others_on_cycles", 32'(others), 0);
        chk("s1_applied_pulses", 32'(n_app - n0), 1);

        // ch2=25 saturates to the full period
        write(2, 25, a);
        do_commit();
        wait_applied(lat);
        run_window(10);
        chk("s2_led2_saturated", 32'(hi[2]), 10);

        // shadow write without commit leaves the output untouched
        write(1, 5, a);
        run_window(50);
        chk("s3_led1_on_cycles", 32'(hi[1]), 0);
        chk("s3_ready_cycles", 32'(hi_rdy), 50);

        // commit on the last cycle of a period waits a full extra period
        wait_cnt(P - 1);
        bus.commit = 1'b1;
        tick1();
        bus.commit     = 1'b0;
        bus.duty_valid = 1'b1;
        bus.duty_ch    = 3'd3;
        bus.duty_val   = DW'(4);
        lat = -1;
        hi_rdy = 0;
        for (int k = 1; k <= 40; k++) begin
            if (applied) begin
                lat = k;
                break;
            end
            hi_rdy += int'(bus.duty_ready);
            tick1();
        end
        chk("s4_commit_to_applied", 32'(lat), 11);
        chk("s4_ready_while_pending", 32'(hi_rdy), 0);
        chk("s4_ready_after_applied", 32'(bus.duty_ready), 1);
        tick1();
        bus.duty_valid = 1'b0;

        // second commit while pending is ignored; held write waits for applied
        n0 = n_app;
        do_commit();
        bus.commit     = 1'b1;
        bus.duty_valid = 1'b1;
        bus.duty_ch    = 3'd4;
        bus.duty_val   = DW'(7);
        chk("s5_ready_pending", 32'(bus.duty_ready), 0);
        tick1();
        bus.commit = 1'b0;
        write(4, 7, a);
        chk("s5_write_after_applied", 32'(a), 1);
        run_window(30);
        chk("s5_single_transfer", 32'(n_app - n0), 1);
        chk("s5_led4_not_applied", 32'(hi[4]), 0);

        // reset with a transfer pending discards shadow and pending state
        write(5, 6, a);
        write(6, 2, a);
        wait_cnt(0);
        do_commit();
        wait_cnt(6);
        chk("s6_pending_before_rst", 32'(bus.duty_ready), 0);
        RST = 1'b1;
        tick1();
        RST = 1'b0;
        chk("s6_led_after_rst", 32'(led), 0);
        n0 = n_app;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick1();
            if (period_tick) begin
                lat = k;
                break;
            end
        end
        chk("s6_first_tick_after_rst", 32'(lat), 9);
        run_window(20);
        chk("s6_no_applied", 32'(n_app - n0), 0);
        do_commit();
        wait_applied(lat);
        run_window(10);
        others = 0;
        for (int i = 0; i < int'(NUM_LEDS); i++) others += hi[i];
        chk("s6_shadow_discarded", 32'(others), 0);

        // random traffic; the per-cycle compare tracks the model
        for (int k = 0; k < 400; k++) begin
            bus.duty_valid = 1'($urandom_range(0, 1));
            bus.duty_ch    = 3'($urandom_range(0, 7));
            bus.duty_val   = DW'($urandom_range(0, 15));
            bus.commit     = ($urandom_range(0, 15) == 0);
            tick1();
        end
        bus.duty_valid = 1'b0;
        bus.commit     = 1'b0;
        repeat (25) tick1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
